// File: rtl/line_sched_pkg.sv
// Shared types and constants for the line render scheduler.
package line_sched_pkg;

   // Fill state of one scanline buffer half.
   typedef enum logic [1:0] {
      HalfFree = 2'd0,
      HalfBusy = 2'd1,
      HalfFull = 2'd2
   } half_state_e;

   // Scheduler FSM states.
   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StScan     = 2'd1,
      StReq      = 2'd2,
      StWaitDone = 2'd3
   } sched_state_e;

   // Scanline buffer geometry: half 0 at 0..639, half 1 at 640..1279.
   localparam int unsigned LINE_HALF_SIZE  = 640;
   localparam int unsigned LINE_HALF1_BASE = 640;

endpackage

// File: rtl/line_buf_tracker.sv
// Fill-state tracker for the two scanline buffer halves (FREE/BUSY/FULL).
module line_buf_tracker
   import line_sched_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clear_i,        // force both halves FREE (mode change)
   input  logic       mark_busy_i,    // request issued for half sel_i
   input  logic       mark_full_i,    // render finished for half sel_i
   input  logic       sel_i,
   input  logic       release_i,
   input  logic       release_idx_i,
   output logic [1:0] free_o,
   output logic [1:0] buf_full_o,
   output logic       underrun_o
);

   half_state_e half_q [2];
   half_state_e half_d [2];
   logic [1:0]  buf_full_q;
   logic [1:0]  buf_full_d;

   // Next half states; clear dominates, release only acts on a FULL half.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         half_d[i] = half_q[i];
         if (clear_i) begin
            half_d[i] = HalfFree;
         end else if (mark_busy_i && (sel_i == i[0])) begin
            half_d[i] = HalfBusy;
         end else if (mark_full_i && (sel_i == i[0])) begin
            half_d[i] = HalfFull;
         end else if (release_i && (release_idx_i == i[0]) && (half_q[i] == HalfFull)) begin
            half_d[i] = HalfFree;
         end
         free_o[i]     = (half_q[i] == HalfFree);
         buf_full_d[i] = (half_d[i] == HalfFull);
      end
      underrun_o = release_i && !clear_i && (half_q[release_idx_i] != HalfFull);
   end

   assign buf_full_o = buf_full_q;

   // Half-state and registered FULL-flag storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         half_q[0]  <= HalfFree;
         half_q[1]  <= HalfFree;
         buf_full_q <= 2'b00;
      end else begin
         half_q[0]  <= half_d[0];
         half_q[1]  <= half_d[1];
         buf_full_q <= buf_full_d;
      end
   end

endmodule

// File: rtl/line_render_scheduler.sv
// Schedules per-line render requests into the two scanline buffer halves.
// Optional underrun statistics are enabled with the LINE_SCHED_STATS_EN macro.
module line_render_scheduler
   import line_sched_pkg::*;
#(
   parameter int unsigned LINE_W = 11
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   input  logic              frame_start,
   input  logic              mode_changed,
   input  logic [LINE_W-1:0] lines_per_frame,
   input  logic              buf_release,
   input  logic              buf_release_idx,
   output logic              render_req,
   output logic [LINE_W-1:0] render_line,
   output logic              render_buf,
   input  logic              render_ack,
   input  logic              render_done,
   output logic              render_abort,
   output logic              frame_done,
   output logic [1:0]        buf_full,
   output logic [15:0]       underrun_cnt
);

   sched_state_e      state_q, state_d;
   logic [LINE_W-1:0] lpf_q, lpf_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              next_buf_q, next_buf_d;
   logic              restart_q, restart_d;
   logic              done_pend_q, done_pend_d;  // render_done seen in the ack cycle
   logic              req_q, req_d;
   logic [LINE_W-1:0] rline_q, rline_d;
   logic              rbuf_q, rbuf_d;
   logic              abort_q, abort_d;
   logic              fdone_q, fdone_d;

   logic       mark_busy, mark_full, clear_all;
   logic [1:0] half_free;
   logic       underrun;

   line_buf_tracker u_tracker (
      .clk_i         (sys_clk),
      .rst_ni        (reset_n),
      .clear_i       (clear_all),
      .mark_busy_i   (mark_busy),
      .mark_full_i   (mark_full),
      .sel_i         (next_buf_q),
      .release_i     (buf_release),
      .release_idx_i (buf_release_idx),
      .free_o        (half_free),
      .buf_full_o    (buf_full),
      .underrun_o    (underrun)
   );

   // FSM next state and registered-output next values; mode change wins over all.
   always_comb begin
      state_d     = state_q;
      lpf_d       = lpf_q;
      line_d      = line_q;
      next_buf_d  = next_buf_q;
      restart_d   = restart_q;
      done_pend_d = done_pend_q;
      req_d       = req_q;
      rline_d     = rline_q;
      rbuf_d      = rbuf_q;
      abort_d     = 1'b0;
      fdone_d     = 1'b0;
      mark_busy   = 1'b0;
      mark_full   = 1'b0;
      clear_all   = 1'b0;

      if (mode_changed) begin
         state_d     = StIdle;
         clear_all   = 1'b1;
         req_d       = 1'b0;
         restart_d   = 1'b0;
         done_pend_d = 1'b0;
         abort_d     = (state_q == StReq) || (state_q == StWaitDone);
      end else begin
         if (frame_start && (state_q != StIdle)) begin
            restart_d = 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (frame_start || restart_q) begin
                  lpf_d      = lines_per_frame;
                  line_d     = '0;
                  next_buf_d = 1'b0;
                  restart_d  = 1'b0;
                  state_d    = StScan;
               end
            end
            StScan: begin
               if (line_q == lpf_q) begin
                  fdone_d = 1'b1;
                  state_d = StIdle;
               end else if (half_free[next_buf_q]) begin
                  rline_d   = line_q;
                  rbuf_d    = next_buf_q;
                  mark_busy = 1'b1;
                  req_d     = 1'b1;
                  state_d   = StReq;
               end
            end
            StReq: begin
               if (render_ack) begin
                  req_d       = 1'b0;
                  done_pend_d = render_done;
                  state_d     = StWaitDone;
               end
            end
            StWaitDone: begin
               if (render_done || done_pend_q) begin
                  mark_full   = 1'b1;
                  done_pend_d = 1'b0;
                  state_d     = StScan;
                  // A frame_start seen during the line restarts at line 0 on entry to SCAN.
                  if (restart_q || frame_start) begin
                     restart_d  = 1'b0;
                     lpf_d      = lines_per_frame;
                     line_d     = '0;
                     next_buf_d = 1'b0;
                  end else begin
                     line_d     = line_q + LINE_W'(1);
                     next_buf_d = ~next_buf_q;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         lpf_q       <= '0;
         line_q      <= '0;
         next_buf_q  <= 1'b0;
         restart_q   <= 1'b0;
         done_pend_q <= 1'b0;
         req_q       <= 1'b0;
         rline_q     <= '0;
         rbuf_q      <= 1'b0;
         abort_q     <= 1'b0;
         fdone_q     <= 1'b0;
      end else begin
         lpf_q       <= lpf_d;
         line_q      <= line_d;
         next_buf_q  <= next_buf_d;
         restart_q   <= restart_d;
         done_pend_q <= done_pend_d;
         req_q       <= req_d;
         rline_q     <= rline_d;
         rbuf_q      <= rbuf_d;
         abort_q     <= abort_d;
         fdone_q     <= fdone_d;
      end
   end

   assign render_req   = req_q;
   assign render_line  = rline_q;
   assign render_buf   = rbuf_q;
   assign render_abort = abort_q;
   assign frame_done   = fdone_q;

`ifdef LINE_SCHED_STATS_EN
   logic [15:0] ucnt_q;

   // Saturating count of releases that hit a FREE or BUSY half.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         ucnt_q <= 16'h0000;
      end else if (underrun && (ucnt_q != 16'hFFFF)) begin
         ucnt_q <= ucnt_q + 16'h0001;
      end
   end

   assign underrun_cnt = ucnt_q;
`else
   logic unused_underrun;
   assign unused_underrun = underrun;
   assign underrun_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_line_render_scheduler.sv
// Directed self-checking bench for line_render_scheduler.
module tb_line_render_scheduler;

   logic        sys_clk = 1'b0;
   logic        reset_n;
   logic        frame_start;
   logic        mode_changed;
   logic [10:0] lines_per_frame;
   logic        buf_release;
   logic        buf_release_idx;
   logic        render_req;
   logic [10:0] render_line;
   logic        render_buf;
   logic        render_ack;
   logic        render_done;
   logic        render_abort;
   logic        frame_done;
   logic [1:0]  buf_full;
   logic [15:0] underrun_cnt;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef LINE_SCHED_STATS_EN
   localparam logic [15:0] ExpUnderrun = 16'd2;
`else
   localparam logic [15:0] ExpUnderrun = 16'd0;
`endif

   line_render_scheduler #(.LINE_W(11)) dut (
      .sys_clk         (sys_clk),
      .reset_n         (reset_n),
      .frame_start     (frame_start),
      .mode_changed    (mode_changed),
      .lines_per_frame (lines_per_frame),
      .buf_release     (buf_release),
      .buf_release_idx (buf_release_idx),
      .render_req      (render_req),
      .render_line     (render_line),
      .render_buf      (render_buf),
      .render_ack      (render_ack),
      .render_done     (render_done),
      .render_abort    (render_abort),
      .frame_done      (frame_done),
      .buf_full        (buf_full),
      .underrun_cnt    (underrun_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required $finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Serve one request that is visible now: ack, optional release, done after 4 more cycles.
   task automatic serve(input logic [10:0] l, input logic b, input bit rel, input logic ridx);
      chk("req_hi", 32'(render_req), 32'd1);
      chk("req_line", 32'(render_line), 32'(l));
      chk("req_buf", 32'(render_buf), 32'(b));
      render_ack = 1'b1;
      step();
      render_ack = 1'b0;
      chk("req_drop_after_ack", 32'(render_req), 32'd0);
      if (rel) begin
         buf_release     = 1'b1;
         buf_release_idx = ridx;
      end
      step();
      buf_release = 1'b0;
      step();
      step();
      render_done = 1'b1;
      step();
      render_done = 1'b0;
      chk("req_lo_in_scan", 32'(render_req), 32'd0);
   endtask

   task automatic release_half(input logic idx);
      buf_release     = 1'b1;
      buf_release_idx = idx;
      step();
      buf_release = 1'b0;
   endtask

   initial begin
      reset_n         = 1'b0;
      frame_start     = 1'b0;
      mode_changed    = 1'b0;
      lines_per_frame = 11'd0;
      buf_release     = 1'b0;
      buf_release_idx = 1'b0;
      render_ack      = 1'b0;
      render_done     = 1'b0;
      step();
      step();
      chk("rst_req", 32'(render_req), 32'd0);
      chk("rst_line", 32'(render_line), 32'd0);
      chk("rst_buf", 32'(render_buf), 32'd0);
      chk("rst_abort", 32'(render_abort), 32'd0);
      chk("rst_fdone", 32'(frame_done), 32'd0);
      chk("rst_full", 32'(buf_full), 32'd0);
      chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
      reset_n = 1'b1;
      step();

      // Three-line frame with releases: halves 0/1/0, one frame_done.
      lines_per_frame = 11'd3;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("fs_req_1cyc", 32'(render_req), 32'd0);
      step();
      serve(11'd0, 1'b0, 1'b0, 1'b0);
      chk("full_after_l0", 32'(buf_full), 32'h1);
      step();
      serve(11'd1, 1'b1, 1'b1, 1'b0);
      chk("full_after_l1", 32'(buf_full), 32'h2);
      step();
      serve(11'd2, 1'b0, 1'b0, 1'b0);
      chk("full_after_l2", 32'(buf_full), 32'h3);
      chk("fdone_early", 32'(frame_done), 32'd0);
      step();
      chk("fdone_pulse", 32'(frame_done), 32'd1);
      chk("fdone_no_req", 32'(render_req), 32'd0);
      step();
      chk("fdone_once", 32'(frame_done), 32'd0);
      release_half(1'b0);
      chk("rel0_1cyc", 32'(buf_full), 32'h2);
      release_half(1'b1);
      chk("rel1_1cyc", 32'(buf_full), 32'h0);

      // Stall with both halves FULL, then release half 0.
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      serve(11'd0, 1'b0, 1'b0, 1'b0);
      step();
      serve(11'd1, 1'b1, 1'b0, 1'b0);
      chk("stall_full", 32'(buf_full), 32'h3);
      step();
      step();
      step();
      chk("stall_req_lo", 32'(render_req), 32'd0);
      release_half(1'b0);
      chk("stall_rel_full", 32'(buf_full), 32'h2);
      chk("stall_rel_req_lo", 32'(render_req), 32'd0);
      step();
      serve(11'd2, 1'b0, 1'b0, 1'b0);
      step();
      chk("stall_fdone", 32'(frame_done), 32'd1);
      release_half(1'b0);
      release_half(1'b1);
      chk("stall_clean", 32'(buf_full), 32'h0);

      // Underruns on BUSY and FREE halves, then mode change in WAIT_DONE and REQ.
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      chk("mc_req_l0", 32'(render_line), 32'd0);
      render_ack = 1'b1;
      step();
      render_ack = 1'b0;
      release_half(1'b0);
      release_half(1'b1);
      chk("ur_full_unchanged", 32'(buf_full), 32'h0);
      chk("ur_cnt", 32'(underrun_cnt), 32'(ExpUnderrun));
      render_done = 1'b1;
      step();
      render_done = 1'b0;
      chk("ur_busy_kept", 32'(buf_full), 32'h1);
      step();
      chk("ur_free_kept_buf", 32'(render_buf), 32'd1);
      chk("ur_free_kept_req", 32'(render_req), 32'd1);
      render_ack = 1'b1;
      step();
      render_ack = 1'b0;
      mode_changed = 1'b1;
      step();
      mode_changed = 1'b0;
      chk("mc_wait_abort", 32'(render_abort), 32'd1);
      chk("mc_wait_req", 32'(render_req), 32'd0);
      chk("mc_wait_full", 32'(buf_full), 32'h0);
      step();
      chk("mc_abort_once", 32'(render_abort), 32'd0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      chk("mc_restart_req", 32'(render_req), 32'd1);
      chk("mc_restart_line", 32'(render_line), 32'd0);
      chk("mc_restart_buf", 32'(render_buf), 32'd0);
      mode_changed = 1'b1;
      step();
      mode_changed = 1'b0;
      chk("mc_req_abort", 32'(render_abort), 32'd1);
      chk("mc_req_req", 32'(render_req), 32'd0);
      step();
      mode_changed = 1'b1;
      step();
      mode_changed = 1'b0;
      chk("mc_idle_no_abort", 32'(render_abort), 32'd0);

      // frame_start while line 5 is in flight restarts at line 0 with the new line count.
      lines_per_frame = 11'd8;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         serve(11'(i), i[0], (i >= 1), ~i[0]);
         step();
      end
      chk("rs_l5_line", 32'(render_line), 32'd5);
      chk("rs_l5_buf", 32'(render_buf), 32'd1);
      render_ack = 1'b1;
      step();
      render_ack = 1'b0;
      lines_per_frame = 11'd2;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      release_half(1'b0);
      step();
      render_done = 1'b1;
      step();
      render_done = 1'b0;
      chk("rs_l5_done_full", 32'(buf_full), 32'h2);
      chk("rs_no_fdone", 32'(frame_done), 32'd0);
      step();
      serve(11'd0, 1'b0, 1'b1, 1'b1);
      step();
      serve(11'd1, 1'b1, 1'b1, 1'b0);
      step();
      chk("rs_new_lpf_fdone", 32'(frame_done), 32'd1);

      // Zero-line frame: frame_done two cycles after frame_start, no request.
      lines_per_frame = 11'd0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("z_fdone_1cyc", 32'(frame_done), 32'd0);
      step();
      chk("z_fdone_2cyc", 32'(frame_done), 32'd1);
      chk("z_req", 32'(render_req), 32'd0);
      step();
      chk("z_fdone_once", 32'(frame_done), 32'd0);
      chk("z_req_after", 32'(render_req), 32'd0);
      chk("final_ucnt", 32'(underrun_cnt), 32'(ExpUnderrun));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
